// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter.
//   ch_w(n)    : width of a channel index, max(1, clog2(n))
//   DEF_N_CH   : default number of input channels
//   DEF_WIDTH  : default data width per channel
package rr_mux_pkg;

    localparam int DEF_N_CH  = 4;
    localparam int DEF_WIDTH = 8;

    // A single channel still needs a 1-bit index so out_ch is never zero-width.
    function automatic int ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between N_CH producers, the arbiter, and one consumer.
//   in_valid  [N_CH]        per-channel request
//   in_data   [N_CH*WIDTH]  flattened channel words, channel i at [i*WIDTH +: WIDTH]
//   in_ready  [N_CH]        per-channel accept, one-hot or zero
//   out_valid               output register holds a word
//   out_data  [WIDTH]       buffered word
//   out_ch    [CH_W]        channel that supplied out_data
//   out_ready               consumer accepts the word
// Modports: slave = arbiter view, master = producer/consumer view.
interface rr_mux_arbiter_if
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH
);
    localparam int CH_W = ch_w(N_CH);

    logic [N_CH-1:0]       in_valid;
    logic [N_CH*WIDTH-1:0] in_data;
    logic [N_CH-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [CH_W-1:0]       out_ch;
    logic                  out_ready;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

endinterface

// File: rtl/rr_mux_arbiter_mux_tree.sv
// Combinational N:1 word selector built from 2:1 mux primitives.
//   in_data [N_CH*WIDTH]  flattened channel words
//   sel     [CH_W]        binary channel index
//   out     [WIDTH]       selected word
// The tree is a heap of 2^LV leaves; leaves beyond N_CH read as zero.

module mux2 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);
    assign y = sel ? b : a;
endmodule

module mux_tree
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [N_CH*WIDTH-1:0]     in_data,
    input  logic [ch_w(N_CH)-1:0]     sel,
    output logic [WIDTH-1:0]          out
);
    localparam int LV = ch_w(N_CH);
    localparam int P  = 1 << LV;

    // Heap layout: node 0 is the root, children of k are 2k+1 and 2k+2,
    // leaves occupy P-1 .. 2P-2 in channel order.
    logic [2*P-2:0][WIDTH-1:0] node;

    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < N_CH) begin : g_used
            assign node[P-1+i] = in_data[i*WIDTH +: WIDTH];
        end else begin : g_pad
            assign node[P-1+i] = '0;
        end
    end

    // The root decides on the index MSB, each deeper level on the next bit.
    for (genvar d = 0; d < LV; d++) begin : g_level
        for (genvar j = 0; j < (1 << d); j++) begin : g_node
            localparam int K = (1 << d) - 1 + j;
            mux2 #(.WIDTH(WIDTH)) u_mux (
                .a   (node[2*K+1]),
                .b   (node[2*K+2]),
                .sel (sel[LV-1-d]),
                .y   (node[K])
            );
        end
    end

    assign out = node[0];

endmodule

// File: rtl/rr_mux_arbiter.sv
// N-channel round-robin arbiter feeding a one-word valid/ready output register.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : rr_mux_arbiter_if.slave (per-channel requests in, one stream out)
// The search starts at ptr and wraps; ptr moves past the winner on every
// transfer only, which bounds the wait of a persistent requester to N_CH grants.
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    rr_mux_arbiter_if.slave     bus
);
    localparam int CH_W = ch_w(N_CH);

    logic [CH_W-1:0]  ptr;
    logic [CH_W-1:0]  grant_idx;
    logic             grant_vld;
    logic             load_en;
    logic             xfer;
    logic [WIDTH-1:0] sel_data;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic [CH_W-1:0]  out_ch_q;

    // Output slot is free when empty or when it drains this cycle.
    assign load_en = !out_valid_q || bus.out_ready;
    assign xfer    = grant_vld && load_en && !rst;

    // NOTE: every always_comb output gets a default before the loop so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        int c;
        grant_vld = 1'b0;
        grant_idx = '0;
        c         = 0;
        for (int k = 0; k < N_CH; k++) begin
            c = int'(ptr) + k;
            if (c >= N_CH) c = c - N_CH;
            if (!grant_vld && bus.in_valid[c]) begin
                grant_vld = 1'b1;
                grant_idx = CH_W'(c);
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        for (int i = 0; i < N_CH; i++) begin
            bus.in_ready[i] = xfer && (grant_idx == CH_W'(i));
        end
    end

    mux_tree #(.N_CH(N_CH), .WIDTH(WIDTH)) u_mux_tree (
        .in_data (bus.in_data),
        .sel     (grant_idx),
        .out     (sel_data)
    );

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr         <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= sel_data;
            out_ch_q    <= grant_idx;
            // Explicit wrap keeps non-power-of-two channel counts in range.
            ptr         <= (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + 1'b1;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench: a 4x8 and a 3x16 arbiter run side by side against a
// behavioural model (scan-from-pointer grant, one-word output buffer).
module tb_rr_mux_arbiter;
    import rr_mux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rr_mux_arbiter_if #(.N_CH(4), .WIDTH(8))  b4 ();
    rr_mux_arbiter_if #(.N_CH(3), .WIDTH(16)) b3 ();

    rr_mux_arbiter #(.N_CH(4), .WIDTH(8))  dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    rr_mux_arbiter #(.N_CH(3), .WIDTH(16)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per DUT (0: 4x8, 1: 3x16).
    logic        m_valid [2];
    logic [63:0] m_data  [2];
    int          m_ch    [2];
    int          m_ptr   [2];
    // Decision captured before the edge.
    int          p_g     [2];
    logic        p_rdy   [2];
    logic [63:0] p_data  [2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int n, input int ptr, input logic [15:0] v);
        for (int k = 0; k < n; k++) begin
            if (v[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    function automatic string sfx(input int d);
        return (d == 0) ? "/n4" : "/n3";
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0;
            m_data[d]  = '0;
            m_ch[d]    = 0;
            m_ptr[d]   = 0;
        end
    endtask

    task automatic pre(input int d);
        logic [15:0] v, act, exp;
        logic        rdy;
        int          g;
        if (d == 0) begin
            v = 16'(b4.in_valid); act = 16'(b4.in_ready); rdy = b4.out_ready;
        end else begin
            v = 16'(b3.in_valid); act = 16'(b3.in_ready); rdy = b3.out_ready;
        end
        g   = pick((d == 0) ? 4 : 3, m_ptr[d], v);
        exp = '0;
        if (rst || !(!m_valid[d] || rdy)) g = -1;
        if (g >= 0) exp[g] = 1'b1;
        p_g[d]   = g;
        p_rdy[d] = rdy;
        p_data[d] = '0;
        if (g >= 0) p_data[d] = (d == 0) ? 64'(b4.in_data[g*8 +: 8]) : 64'(b3.in_data[g*16 +: 16]);
        check({"in_ready", sfx(d)}, act, exp);
    endtask

    task automatic post(input int d);
        if (d == 0) begin
            check({"out_valid", sfx(d)}, 64'(b4.out_valid), 64'(m_valid[d]));
            check({"out_data", sfx(d)},  64'(b4.out_data),  m_data[d]);
            check({"out_ch", sfx(d)},    64'(b4.out_ch),    64'(m_ch[d]));
        end else begin
            check({"out_valid", sfx(d)}, 64'(b3.out_valid), 64'(m_valid[d]));
            check({"out_data", sfx(d)},  64'(b3.out_data),  m_data[d]);
            check({"out_ch", sfx(d)},    64'(b3.out_ch),    64'(m_ch[d]));
        end
    endtask

    // One clock: check combinational ready, advance model at the edge, check outputs.
    task automatic step();
        #1;
        pre(0);
        pre(1);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (p_g[d] >= 0) begin
                    m_valid[d] = 1'b1;
                    m_data[d]  = p_data[d];
                    m_ch[d]    = p_g[d];
                    m_ptr[d]   = (p_g[d] + 1) % ((d == 0) ? 4 : 3);
                end else if (p_rdy[d]) begin
                    m_valid[d] = 1'b0;
                end
            end
        end
        #1;
        post(0);
        post(1);
    endtask

    task automatic fill_default();
        b4.in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        b3.in_data = {16'h0302, 16'h0201, 16'h0100};
        b4.in_valid = 4'hF;
        b3.in_valid = 3'h7;
    endtask

    task automatic reset_cycles(input int n);
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < n; i++) step();
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0]  seq4 [5];
        logic [2:0]  ch3  [4];
        seq4 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        ch3  = '{3'd0, 3'd1, 3'd2, 3'd0};

        // Reset with every channel requesting, then a full rotation.
        fill_default();
        b4.out_ready = 1'b1;
        b3.out_ready = 1'b1;
        rst = 1'b1;
        model_reset();
        #2;
        reset_cycles(3);
        for (int i = 0; i < 5; i++) begin
            step();
            check("seq_data/n4", 64'(b4.out_data), 64'(seq4[i]));
            check("seq_ch/n4", 64'(b4.out_ch), 64'(i % 4));
            if (i < 4) check("seq_ch/n3", 64'(b3.out_ch), 64'(ch3[i]));
        end

        // Backpressure after the first load, then release with no bubble.
        reset_cycles(1);
        b4.out_ready = 1'b0;
        b3.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("bp_hold/n4", 64'(b4.out_data), 64'h10);
        end
        b4.out_ready = 1'b1;
        b3.out_ready = 1'b1;
        step();
        check("bp_next/n4", 64'(b4.out_data), 64'h11);
        check("bp_valid/n4", 64'(b4.out_valid), 64'h1);

        // Sparse requests with pointer wrap, then drain and reload in one edge.
        reset_cycles(1);
        b4.in_valid = 4'b0100; b4.in_data = {8'h00, 8'hA2, 8'h00, 8'h00};
        b3.in_valid = 3'b100;
        step();
        check("sparse_ch2/n4", 64'(b4.out_ch), 64'd2);
        b4.in_valid = 4'b0010; b4.in_data = {8'h00, 8'h00, 8'hB1, 8'h00};
        b3.in_valid = 3'b010;
        step();
        check("sparse_ch1/n4", 64'(b4.out_data), 64'hB1);
        b4.in_valid = 4'b1000; b4.in_data = {8'h33, 8'h00, 8'h00, 8'h00};
        b3.in_valid = 3'b001;
        step();
        check("reload_ch3/n4", 64'(b4.out_ch), 64'd3);
        b4.in_valid = '0;
        b3.in_valid = '0;
        step();
        step();

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            b4.in_valid  = 4'($urandom);
            b4.in_data   = 32'($urandom);
            b4.out_ready = ($urandom_range(0, 9) < 7);
            b3.in_valid  = 3'($urandom);
            b3.in_data   = 48'({$urandom, $urandom});
            b3.out_ready = ($urandom_range(0, 9) < 6);
            step();
        end

        // Mid-stream asynchronous reset while a word is held under backpressure.
        fill_default();
        b4.out_ready = 1'b0;
        b3.out_ready = 1'b0;
        step();
        step();
        rst = 1'b1;
        model_reset();
        #2;
        check("async_rst_valid/n4", 64'(b4.out_valid), 64'h0);
        check("async_rst_valid/n3", 64'(b3.out_valid), 64'h0);
        step();
        rst = 1'b0;
        b4.out_ready = 1'b1;
        b3.out_ready = 1'b1;
        step();
        check("post_rst_ch/n4", 64'(b4.out_ch), 64'd0);
        check("post_rst_ch/n3", 64'(b3.out_ch), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
